instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the MIPS control/decode path: takes symbolic instructions (mnemonic + register/immediate fields) over a valid/ready stream and encodes them into 32-bit MIPS machine words.
- Writes the words sequentially into the instruction-memory write port, so test programs can be loaded into the single-cycle core without hex files.
- Covers the same instruction subset the core decodes: add, sub, and, or, slt, nor, mul, div, lw, sw, beq.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory write port.
- DEPTH, 64, number of words loadable per session; must satisfy DEPTH <= 2**ADDR_W.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse: begin a load session at BASE_ADDR, clear count and err.
- finish  in  1  one-cycle pulse: end the session.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  block can accept a beat.
- in_mnem  in  4  mnemonic code.
- in_rs  in  5  rs field (lw/sw base register).
- in_rt  in  5  rt field.
- in_rd  in  5  rd field (R-type only).
- in_imm  in  16  immediate/offset (lw, sw, beq).
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count == DEPTH.
- busy  out  1  session active (LOAD state).
- err  out  1  sticky: an illegal mnemonic was received this session.

Behaviour:
- Reset (rst_n=0 at a clk edge), synchronous:
  - state = IDLE.
  - in_ready, imem_we, busy, full, err = 0; count = 0; imem_addr = BASE_ADDR; imem_wdata = 0.
- States: IDLE, LOAD, DONE.
  - IDLE --start--> LOAD.
  - LOAD --finish--> DONE.
  - DONE --start--> LOAD.
  - start in LOAD restarts the session.
  - start has priority over finish when both are asserted.
- in_ready = (state==LOAD) && !full. A beat is accepted when in_valid && in_ready.
- Latency: an accepted beat produces imem_we=1 for exactly one cycle, on the cycle after acceptance (one register stage).
  - imem_addr = BASE_ADDR + count-before-increment.
  - count increments in that same write cycle.
  - Back-to-back beats are accepted every cycle, giving one write per cycle.
- Encoding, fields [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt=0, [5:0] funct:
  - 0 ADD: op 000000, funct 100000.
  - 1 SUB: funct 100010.
  - 2 AND: funct 100100.
  - 3 OR: funct 100101.
  - 4 SLT: funct 101010.
  - 5 NOR: funct 100111.
  - 6 MUL: funct 011000.
  - 7 DIV: funct 011010.
  - 8 LW: op 100011, rs, rt, imm.
  - 9 SW: op 101011, rs, rt, imm.
  - 10 BEQ: op 000100, rs, rt, imm. imm is passed unmodified; the caller supplies the word offset.
  - I-type encodings ignore in_rd. R-type encodings ignore in_imm.
- Illegal mnemonic (11-15):
  - The beat is accepted (handshake completes) but no write occurs and count is unchanged.
  - err is set in the write-stage cycle and stays set until the next start or reset.
- Full:
  - When count reaches DEPTH, full=1 and in_ready=0.
  - The block stays in LOAD until finish or start.
  - Address never wraps.
- finish in the same cycle as an accepted beat: the beat is still written on the next cycle. in_ready is 0 from the cycle after finish.
- start while a write is pending in the register stage: the pending write is cancelled (imem_we=0), count=0, err=0.
- Reset mid-session: all state returns to reset values immediately; a pending write is dropped.
- In DONE, count and err hold their values for readout. imem_we=0.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ) and funct constants, which are also used by control_unit.
  - Mnemonic enum codes 0-10.
  - Field bit-position constants.
- Sub-module instr_encode: purely combinational mnemonic+fields -> {word, illegal}. It is reusable by testbenches as a golden assembler.
- FSM, handshake, register stage and address counter stay in instr_encoder_loader.

Test Plan:
- start, then ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, addr=0, wdata=0x00221820, count=1.
- Back-to-back SUB rs=6 rt=7 rd=5, LW rs=9 rt=8 imm=4, SW rs=9 rt=8 imm=8, BEQ rs=1 rt=2 imm=0xFFFF -> consecutive writes:
  - addr 0: 0x00C72822
  - addr 1: 0x8D280004
  - addr 2: 0xAD280008
  - addr 3: 0x1022FFFF
  - final count = 4
- mnem=12 between two ADDs -> err=1, only 2 writes at addr 0,1, count=2. A subsequent start clears err.
- DEPTH=4, stream 6 valid beats -> 4 writes, full=1, in_ready=0 after the 4th accept, no write to addr 4.
- finish coincident with an accepted beat -> that beat is written, in_ready=0 afterwards, state DONE, count retained. Then start -> addr returns to BASE_ADDR, count=0.
- rst_n=0 for one cycle while a beat sits in the register stage -> no imem_we, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes, field positions and
// the loader's mnemonic codes. Also used by the core's control_unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [3:0] {
    MN_ADD = 4'd0,
    MN_SUB = 4'd1,
    MN_AND = 4'd2,
    MN_OR  = 4'd3,
    MN_SLT = 4'd4,
    MN_NOR = 4'd5,
    MN_MUL = 4'd6,
    MN_DIV = 4'd7,
    MN_LW  = 4'd8,
    MN_SW  = 4'd9,
    MN_BEQ = 4'd10
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } load_state_e;

  // R-type words always carry shamt = 0.
  function automatic logic [31:0] r_word(input logic [5:0] funct, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(5'd0) << SHAMT_LSB) | 32'(funct);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational assembler: mnemonic plus register/immediate fields to a
// 32-bit MIPS word. Codes outside the supported subset raise illegal.
module instr_encode
  import mips_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = r_word(FUNCT_ADD, rs, rt, rd);
      MN_SUB:  word = r_word(FUNCT_SUB, rs, rt, rd);
      MN_AND:  word = r_word(FUNCT_AND, rs, rt, rd);
      MN_OR:   word = r_word(FUNCT_OR,  rs, rt, rd);
      MN_SLT:  word = r_word(FUNCT_SLT, rs, rt, rd);
      MN_NOR:  word = r_word(FUNCT_NOR, rs, rt, rd);
      MN_MUL:  word = r_word(FUNCT_MUL, rs, rt, rd);
      MN_DIV:  word = r_word(FUNCT_DIV, rs, rt, rd);
      MN_LW:   word = i_word(OP_LW,  rs, rt, imm);
      MN_SW:   word = i_word(OP_SW,  rs, rt, imm);
      MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic instructions in, encodes them and writes the words into
// consecutive instruction-memory locations starting at BASE_ADDR.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

  load_state_e state, state_nxt;
  logic        accept;
  logic [31:0] enc_word;
  logic        enc_illegal;

  instr_encode u_encode (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign full     = (count == LIMIT);
  assign busy     = (state == ST_LOAD);
  assign in_ready = busy && !full;
  assign accept   = in_valid && in_ready;

  // start wins over finish and restarts a session from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (start)       state_nxt = ST_LOAD;
        else if (finish) state_nxt = ST_DONE;
      end
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Write register stage. A beat accepted alongside start is dropped, since
  // the new session must begin with an empty program at BASE_ADDR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        imem_addr <= BASE;
        count     <= '0;
        err       <= 1'b0;
      end else if (accept) begin
        if (enc_illegal) begin
          err <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE + count[ADDR_W-1:0];
          imem_wdata <= enc_word;
          count      <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops
// and compares every imem write. DEPTH=4, BASE_ADDR=16 to exercise full/base.
module tb_instr_encoder_loader;

  localparam int ADDR_W    = 6;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, finish, in_valid;
  logic              in_ready;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, busy, err;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .err        (err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic [ADDR_W:0]   cnt;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  sb_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required none",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr",  64'(imem_addr),  64'(e.addr));
        check("wr_data",  64'(imem_wdata), 64'(e.word));
        check("wr_count", 64'(count),      64'(e.cnt));
      end
    end
  end

  // Drive one beat for a cycle; wr says whether the bench expects a write.
  task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] word,
                      input logic exp_ready, input bit wr);
    in_valid = 1'b1;
    in_mnem  = m;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    check("in_ready_at_beat", 64'(in_ready), 64'(exp_ready));
    if (wr) begin
      exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + sb_count), word: word,
                        cnt: (ADDR_W + 1)'(sb_count + 1)});
      sb_count++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sb_count = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready),   64'(0));
    check("rst_imem_we",  64'(imem_we),    64'(0));
    check("rst_busy",     64'(busy),       64'(0));
    check("rst_full",     64'(full),       64'(0));
    check("rst_err",      64'(err),        64'(0));
    check("rst_count",    64'(count),      64'(0));
    check("rst_addr",     64'(imem_addr),  64'(BASE_ADDR));
    check("rst_wdata",    64'(imem_wdata), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", 64'(in_ready), 64'(0));

    // Single ADD; imm must be ignored by R-type encoding.
    pulse_start();
    check("load_busy", 64'(busy), 64'(1));
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 32'h0022_1820, 1'b1, 1'b1);
    idle();
    check("add_count", 64'(count), 64'(1));

    // Restart, back-to-back stream into full; rd must be ignored by LW.
    pulse_start();
    check("restart_count", 64'(count), 64'(0));
    send(4'd1,  5'd6, 5'd7, 5'd5,  16'h0000, 32'h00C7_2822, 1'b1, 1'b1);
    send(4'd8,  5'd9, 5'd8, 5'd31, 16'h0004, 32'h8D28_0004, 1'b1, 1'b1);
    send(4'd9,  5'd9, 5'd8, 5'd0,  16'h0008, 32'hAD28_0008, 1'b1, 1'b1);
    send(4'd10, 5'd1, 5'd2, 5'd0,  16'hFFFF, 32'h1022_FFFF, 1'b1, 1'b1);
    send(4'd0,  5'd1, 5'd2, 5'd3,  16'h0000, 32'h0022_1820, 1'b0, 1'b0);
    send(4'd0,  5'd1, 5'd2, 5'd3,  16'h0000, 32'h0022_1820, 1'b0, 1'b0);
    idle();
    check("full_flag",  64'(full),     64'(1));
    check("full_count", 64'(count),    64'(4));
    check("full_busy",  64'(busy),     64'(1));
    check("full_ready", 64'(in_ready), 64'(0));

    // Illegal mnemonic between two ADDs.
    pulse_start();
    send(4'd0,  5'd1, 5'd2, 5'd3, 16'h0, 32'h0022_1820, 1'b1, 1'b1);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0,         1'b1, 1'b0);
    send(4'd0,  5'd1, 5'd2, 5'd3, 16'h0, 32'h0022_1820, 1'b1, 1'b1);
    idle();
    check("illegal_err",   64'(err),   64'(1));
    check("illegal_count", 64'(count), 64'(2));
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b1, 1'b0);
    idle();
    check("illegal15_count", 64'(count), 64'(2));
    check("err_sticky",      64'(err),   64'(1));
    pulse_start();
    check("start_clears_err", 64'(err),       64'(0));
    check("start_addr_base",  64'(imem_addr), 64'(BASE_ADDR));

    // Remaining R-types; finish coincides with the second beat.
    send(4'd4, 5'd2, 5'd3, 5'd4, 16'h0, 32'h0043_202A, 1'b1, 1'b1);
    finish = 1'b1;
    send(4'd5, 5'd1, 5'd1, 5'd1, 16'h0, 32'h0021_0827, 1'b1, 1'b1);
    idle();
    check("finish_ready", 64'(in_ready), 64'(0));
    check("finish_busy",  64'(busy),     64'(0));
    check("finish_count", 64'(count),    64'(2));
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0022_1820, 1'b0, 1'b0);
    idle();
    check("done_hold_count", 64'(count), 64'(2));

    // Restart from DONE: remaining R-type encodings.
    pulse_start();
    check("redo_count", 64'(count),     64'(0));
    check("redo_addr",  64'(imem_addr), 64'(BASE_ADDR));
    send(4'd6, 5'd8,  5'd9, 5'd10, 16'h0, 32'h0109_5018, 1'b1, 1'b1);
    send(4'd7, 5'd3,  5'd4, 5'd0,  16'h0, 32'h0064_001A, 1'b1, 1'b1);
    send(4'd2, 5'd4,  5'd5, 5'd6,  16'h0, 32'h0085_3024, 1'b1, 1'b1);
    send(4'd3, 5'd31, 5'd0, 5'd31, 16'h0, 32'h03E0_F825, 1'b1, 1'b1);
    idle();
    check("second_full", 64'(full), 64'(1));

    // start together with an accepted beat cancels that write.
    pulse_start();
    start = 1'b1;
    sb_count = 0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0022_1820, 1'b1, 1'b0);
    idle();
    check("start_cancel_count", 64'(count), 64'(0));
    check("start_cancel_busy",  64'(busy),  64'(1));

    // Reset while a beat is being accepted: no write, reset values.
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0022_1820, 1'b1, 1'b1);
    rst_n = 1'b0;
    send(4'd1, 5'd6, 5'd7, 5'd5, 16'h0, 32'h00C7_2822, 1'b1, 1'b0);
    idle();
    rst_n = 1'b1;
    check("mid_rst_we",    64'(imem_we),    64'(0));
    check("mid_rst_busy",  64'(busy),       64'(0));
    check("mid_rst_count", 64'(count),      64'(0));
    check("mid_rst_addr",  64'(imem_addr),  64'(BASE_ADDR));
    check("mid_rst_wdata", 64'(imem_wdata), 64'(0));
    check("mid_rst_ready", 64'(in_ready),   64'(0));

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
